vp_recovery_sequencer: RTL
==========================

VP_RECOVERY_SEQUENCER -- requirements
Module: vp_recovery_sequencer

Interface
REQ-001 Parameters: DATA_WIDTH, default 32, load data width; ADDR_WIDTH, default 32, PC width; CNT_WIDTH, default 16, statistics counter width.
REQ-002 clk  in  1  clock; single clock domain, all state updates on its rising edge.
REQ-003 rst  in  1  synchronous reset, active-high.
REQ-004 ld_req_valid  in  1  memory stage presents a data access this cycle.
REQ-005 ld_req_write  in  1  access is a store (1) or load (0).
REQ-006 ld_req_hit  in  1  d-cache hit for the access this cycle.
REQ-007 ld_req_pc  in  ADDR_WIDTH  PC of the access.
REQ-008 pred_valid  in  1  / pred_data  in  DATA_WIDTH  value predictor response.
REQ-009 fill_valid  in  1  / fill_data  in  DATA_WIDTH  d-cache miss fill (true value).
REQ-010 snap_ack  in  1  register snapshot captured; restore_done  in  1  snapshot restore complete.
REQ-011 vp_en  out  1  request prediction; snap_take  out  1  capture register snapshot.
REQ-012 use_pred  out  1  select pred_data as the memory-stage load result.
REQ-013 snap_restore  out  1  restore registers from snapshot.
REQ-014 mem_ovr_stall  out  1  stall IF/DEC/EX/MEM; flush_all  out  1  flush IF/DEC/EX/MEM.
REQ-015 load_pc_we  out  1  / load_pc_new  out  ADDR_WIDTH  PC redirect.
REQ-016 busy  out  1  state != IDLE; train_valid  out  1  / train_correct  out  1  predictor training.
REQ-017 stat_pred  out  CNT_WIDTH  / stat_mispred  out  CNT_WIDTH  predictions issued / mispredicted.

Function
REQ-018 FSM states: IDLE, WAIT_PRED, SPEC, RESTORE, REDIRECT.
REQ-019 IDLE: ld_req_valid & ~ld_req_write & ~ld_req_hit -> vp_en=1 and snap_take=1 for that single cycle, latch ld_req_pc into spec_pc, clear got_ack/got_pred flags, next WAIT_PRED; any other access -> remain IDLE, no outputs.
REQ-020 WAIT_PRED: set got_ack on snap_ack, latch pred_data and set got_pred on pred_valid; events may arrive in any order or the same cycle.
REQ-021 WAIT_PRED: when both flags are set (including set this cycle), use_pred=1 for exactly one cycle, stat_pred increments, next SPEC.
REQ-022 WAIT_PRED: fill_valid before the prediction is complete -> abandon speculation, no use_pred, no training, stat_pred unchanged, next IDLE; fill has priority over a same-cycle pred_valid.
REQ-023 SPEC and WAIT_PRED: ld_req_valid (load or store) -> mem_ovr_stall=1 combinationally in the same cycle; no second speculation is ever opened.
REQ-024 SPEC: fill_valid compares fill_data to the latched prediction over all DATA_WIDTH bits; train_valid=1 for one cycle with train_correct=equal.
REQ-025 SPEC, equal: next IDLE, no flush, no redirect.
REQ-026 SPEC, not equal: stat_mispred increments, next RESTORE.
REQ-027 RESTORE: snap_restore=1 and mem_ovr_stall=1 held every cycle until restore_done is sampled high; then next REDIRECT.
REQ-028 REDIRECT (one cycle): flush_all=1, load_pc_we=1, load_pc_new=spec_pc; mem_ovr_stall=0; next IDLE. The load re-executes and hits.
REQ-029 load_pc_new=0 whenever load_pc_we=0.
REQ-030 Statistics counters saturate at all-ones, no wrap.
REQ-031 Inputs not valid in the current state (pred_valid in IDLE, restore_done outside RESTORE, etc.) are ignored.
REQ-032 No combinational path from pred_data/fill_data to any control output except via the REQ-024 comparison into train_correct.

Reset
REQ-033 rst=1 -> next state IDLE, flags and spec_pc cleared, stat_pred=stat_mispred=0; all outputs 0 in the cycle after the sampled reset.
REQ-034 Reset in any state, including mid-RESTORE, abandons the sequence; no redirect, no flush, no training pulse is issued.

Verification
REQ-035 Correct prediction: load miss pc=0x0040_0100; pred 0xDEAD_BEEF 2 cycles later, snap_ack 1 cycle later; fill 0xDEAD_BEEF -> use_pred 1 cycle; train_valid=1/train_correct=1; stat_pred=1, stat_mispred=0; no flush.
REQ-036 Mispredict: pred 0x1, fill 0x2, restore_done 3 cycles after RESTORE entry -> snap_restore high exactly 3 cycles; then 1 cycle flush_all=1, load_pc_we=1, load_pc_new=0x0040_0100; stat_mispred=1.
REQ-037 Second access while in SPEC: store at cycle N -> mem_ovr_stall=1 in cycle N; FSM remains SPEC.
REQ-038 Fill before prediction: fill_valid and pred_valid in the same cycle in WAIT_PRED -> IDLE next; use_pred never asserted; stat_pred=0.
REQ-039 Hit/store in IDLE: store or hitting load -> vp_en=snap_take=0; busy stays 0.
REQ-040 Reset during RESTORE -> all outputs 0 next cycle, IDLE, no load_pc_we pulse; saturation: preset 0xFFFF plus 1 more prediction -> stat_pred stays 0xFFFF.

Source files
------------

// File: rtl/vp_recovery_sequencer.sv
// -----------------------------------------------------------------------------
// vp_recovery_sequencer
//
// Purpose
//   Value-prediction recovery controller for a d-cache load miss. When a load
//   misses, the sequencer asks the value predictor for a guess and has the
//   register file take a snapshot. Once both are in hand, the memory stage
//   consumes the predicted value and the pipeline runs ahead speculatively.
//   When the true fill arrives it is compared with the guess:
//     - equal     : speculation is confirmed, nothing to undo;
//     - not equal : registers are restored from the snapshot, the front of the
//                   pipeline is flushed and the PC is redirected back to the
//                   load so it re-executes and hits in the cache.
//   Only one speculation is open at a time; further memory accesses are
//   stalled while one is in flight.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   ld_req_valid/write/hit/pc      memory-stage access and its d-cache result
//   pred_valid, pred_data          value predictor response
//   fill_valid, fill_data          d-cache miss fill (true value)
//   snap_ack, restore_done         snapshot captured / restore finished
//   vp_en, snap_take               request prediction / capture snapshot
//   use_pred                       select pred_data as the load result
//   snap_restore                   restore registers from snapshot
//   mem_ovr_stall, flush_all       stall / flush IF, DEC, EX, MEM
//   load_pc_we, load_pc_new        PC redirect (load_pc_new is 0 when idle)
//   busy                           sequencer is not idle
//   train_valid, train_correct     predictor training pulse and verdict
//   stat_pred, stat_mispred        saturating prediction statistics
//
// States
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   IDLE      | no speculation open; a load miss opens one
//   WAIT_PRED | waiting for both the prediction and the snapshot acknowledge
//   SPEC      | predicted value consumed; waiting for the true fill
//   RESTORE   | mispredicted; registers being restored from the snapshot
//   REDIRECT  | one cycle of flush plus PC redirect back to the load
// -----------------------------------------------------------------------------
module vp_recovery_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  ld_req_valid,
    input  logic                  ld_req_write,
    input  logic                  ld_req_hit,
    input  logic [ADDR_WIDTH-1:0] ld_req_pc,

    input  logic                  pred_valid,
    input  logic [DATA_WIDTH-1:0] pred_data,

    input  logic                  fill_valid,
    input  logic [DATA_WIDTH-1:0] fill_data,

    input  logic                  snap_ack,
    input  logic                  restore_done,

    output logic                  vp_en,
    output logic                  snap_take,
    output logic                  use_pred,
    output logic                  snap_restore,
    output logic                  mem_ovr_stall,
    output logic                  flush_all,
    output logic                  load_pc_we,
    output logic [ADDR_WIDTH-1:0] load_pc_new,
    output logic                  busy,
    output logic                  train_valid,
    output logic                  train_correct,
    output logic [CNT_WIDTH-1:0]  stat_pred,
    output logic [CNT_WIDTH-1:0]  stat_mispred
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_PRED = 3'd1,
        SPEC      = 3'd2,
        RESTORE   = 3'd3,
        REDIRECT  = 3'd4
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] spec_pc;
    logic [DATA_WIDTH-1:0] pred_q;
    logic                  got_ack;
    logic                  got_pred;

    // Registered copies of the state-derived outputs, updated together with
    // the state so they line up exactly with it.
    logic                  busy_q;
    logic                  restore_q;
    logic                  redirect_q;
    logic [ADDR_WIDTH-1:0] pc_new_q;
    logic [CNT_WIDTH-1:0]  stat_pred_q;
    logic [CNT_WIDTH-1:0]  stat_mispred_q;

    logic load_miss;
    logic in_wait;
    logic in_spec;
    logic ack_now;
    logic pred_now;
    logic open_spec;
    logic pred_done;
    logic fill_in_spec;
    logic fill_match;

    assign load_miss = ld_req_valid & ~ld_req_write & ~ld_req_hit;
    assign in_wait   = (state == WAIT_PRED);
    assign in_spec   = (state == SPEC);

    // Acknowledge and prediction may each arrive before, or in the same cycle
    // as, the other; the sticky flag covers earlier arrivals.
    assign ack_now  = got_ack  | snap_ack;
    assign pred_now = got_pred | pred_valid;

    assign open_spec = ~rst & (state == IDLE) & load_miss;

    // A fill seen while still waiting kills the speculation, even when the
    // last missing event arrives in the same cycle.
    assign pred_done = ~rst & in_wait & ~fill_valid & ack_now & pred_now;

    assign fill_in_spec = ~rst & in_spec & fill_valid;

    // The only place the data buses reach a control output.
    assign fill_match = (fill_data == pred_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            spec_pc        <= '0;
            pred_q         <= '0;
            got_ack        <= 1'b0;
            got_pred       <= 1'b0;
            busy_q         <= 1'b0;
            restore_q      <= 1'b0;
            redirect_q     <= 1'b0;
            pc_new_q       <= '0;
            stat_pred_q    <= '0;
            stat_mispred_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_miss) begin
                        state    <= WAIT_PRED;
                        spec_pc  <= ld_req_pc;
                        got_ack  <= 1'b0;
                        got_pred <= 1'b0;
                        busy_q   <= 1'b1;
                    end
                end

                WAIT_PRED: begin
                    if (fill_valid) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        if (snap_ack) begin
                            got_ack <= 1'b1;
                        end
                        if (pred_valid) begin
                            got_pred <= 1'b1;
                            pred_q   <= pred_data;
                        end
                        if (ack_now && pred_now) begin
                            state <= SPEC;
                            if (stat_pred_q != '1) begin
                                stat_pred_q <= stat_pred_q + CNT_WIDTH'(1);
                            end
                        end
                    end
                end

                SPEC: begin
                    if (fill_valid) begin
                        if (fill_match) begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end else begin
                            state     <= RESTORE;
                            restore_q <= 1'b1;
                            if (stat_mispred_q != '1) begin
                                stat_mispred_q <= stat_mispred_q + CNT_WIDTH'(1);
                            end
                        end
                    end
                end

                RESTORE: begin
                    if (restore_done) begin
                        state      <= REDIRECT;
                        restore_q  <= 1'b0;
                        redirect_q <= 1'b1;
                        pc_new_q   <= spec_pc;
                    end
                end

                REDIRECT: begin
                    state      <= IDLE;
                    redirect_q <= 1'b0;
                    pc_new_q   <= '0;
                    busy_q     <= 1'b0;
                end

                default: begin
                    state      <= IDLE;
                    busy_q     <= 1'b0;
                    restore_q  <= 1'b0;
                    redirect_q <= 1'b0;
                    pc_new_q   <= '0;
                end
            endcase
        end
    end

    // Event-driven pulses follow the inputs in the same cycle.
    assign vp_en         = open_spec;
    assign snap_take     = open_spec;
    assign use_pred      = pred_done;
    assign train_valid   = fill_in_spec;
    assign train_correct = fill_in_spec & fill_match;

    // Outputs are forced quiet while reset is asserted so that a reset taken
    // mid-sequence never lets a restore, flush or redirect escape.
    assign mem_ovr_stall = ~rst & (restore_q | ((in_wait | in_spec) & ld_req_valid));
    assign snap_restore  = ~rst & restore_q;
    assign flush_all     = ~rst & redirect_q;
    assign load_pc_we    = ~rst & redirect_q;
    assign load_pc_new   = rst ? '0 : pc_new_q;
    assign busy          = ~rst & busy_q;

    assign stat_pred    = stat_pred_q;
    assign stat_mispred = stat_mispred_q;

endmodule
